// File: rtl/result_frame_reader.sv
// Streams a finished frame back out of image memory as raster-ordered pixels.
// Reads are credit-limited so in-flight requests plus buffered pixels never
// exceed the response buffer; the buffer head drives the output directly.
module result_frame_reader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DIM_WIDTH  = 12,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic [DIM_WIDTH-1:0]  width,
  input  logic [DIM_WIDTH-1:0]  length,
  input  logic [ADDR_WIDTH-1:0] initial_addr_w,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic [DIM_WIDTH-1:0]  pix_row,
  output logic [DIM_WIDTH-1:0]  pix_col,
  output logic                  pix_last,
  output logic                  busy,
  output logic                  done
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 2;            // holds outstanding + count (<= 2*depth)
  localparam int NW = 2 * DIM_WIDTH;     // frame pixel count width
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t                state, state_nxt;
  logic [DIM_WIDTH-1:0]  width_q, length_q;
  logic [NW-1:0]         total_q, issued_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CW-1:0]         outstanding_q, count_q;
  logic [PW-1:0]         wptr_q, rptr_q;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [DIM_WIDTH-1:0]  row_q, col_q;
  logic                  done_q;

  logic active, start_ok, credit_ok, issue, push, pop;
  logic at_last_col, frame_last;

  assign active      = (state == ISSUE) || (state == DRAIN);
  assign start_ok    = (state == IDLE) && start;
  // Registered totals already include every earlier read, so allowing one more
  // read only while the sum is below depth can never overfill the buffer.
  assign credit_ok   = (outstanding_q + count_q) < DEPTH_C;
  assign issue       = (state == ISSUE) && credit_ok;
  // Responses outside an active frame are stale and must not touch any state.
  assign push        = active && mem_rvalid;
  assign pop         = pix_valid && pix_ready;
  assign at_last_col = (col_q == width_q - DIM_WIDTH'(1));
  assign frame_last  = at_last_col && (row_q == length_q - DIM_WIDTH'(1));

  assign mem_ren   = issue;
  assign mem_addr  = addr_q;
  assign pix_valid = (count_q != '0);
  assign pix_data  = pix_valid ? fifo_mem[rptr_q] : '0;
  assign pix_row   = row_q;
  assign pix_col   = col_q;
  assign pix_last  = pix_valid && frame_last;
  assign busy      = active;
  assign done      = done_q;

  // State register
  always_ff @(posedge clk) begin
    if (n_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: empty frames skip straight to the completion pulse
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (width == '0 || length == '0) state_nxt = FIN;
          else                             state_nxt = ISSUE;
        end
      end
      ISSUE: if (issue && issued_q == total_q - NW'(1)) state_nxt = DRAIN;
      DRAIN: if (pop && frame_last)                    state_nxt = FIN;
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Response buffer storage; contents are meaningless unless counted valid
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_q] <= mem_rdata;
  end

  // Frame parameters, address/credit counters, buffer pointers, pixel position
  always_ff @(posedge clk) begin
    if (n_rst) begin
      width_q       <= '0;
      length_q      <= '0;
      total_q       <= '0;
      issued_q      <= '0;
      addr_q        <= '0;
      outstanding_q <= '0;
      count_q       <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      row_q         <= '0;
      col_q         <= '0;
      done_q        <= 1'b0;
    end else begin
      if (start_ok) begin
        width_q  <= width;
        length_q <= length;
        total_q  <= NW'(width) * NW'(length);
        issued_q <= '0;
        addr_q   <= initial_addr_w;
        row_q    <= '0;
        col_q    <= '0;
      end
      if (issue) begin
        addr_q   <= addr_q + ADDR_WIDTH'(1);
        issued_q <= issued_q + NW'(1);
      end
      case ({issue, push})
        2'b10:   outstanding_q <= outstanding_q + CW'(1);
        2'b01:   outstanding_q <= outstanding_q - CW'(1);
        default: outstanding_q <= outstanding_q;
      endcase
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      // Position holds on the final pixel so it stays readable after the frame
      if (pop && !frame_last) begin
        if (at_last_col) begin
          col_q <= '0;
          row_q <= row_q + DIM_WIDTH'(1);
        end else begin
          col_q <= col_q + DIM_WIDTH'(1);
        end
      end
      done_q <= (state == FIN);
    end
  end

endmodule

// File: tb/tb_result_frame_reader.sv
// Randomized bench: a memory model with variable in-order latency, a
// frame-level reference model feeding expected queues, and a decoupled monitor.
module tb_result_frame_reader;
  localparam int AW = 16, DW = 12, DTW = 8, FD = 4;

  logic clk = 1'b0, n_rst = 1'b1, start = 1'b0;
  logic [DW-1:0] width = '0, length = '0;
  logic [AW-1:0] initial_addr_w = '0;
  logic mem_ren, mem_rvalid = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DTW-1:0] mem_rdata = '0;
  logic pix_valid, pix_ready = 1'b0, pix_last, busy, done;
  logic [DTW-1:0] pix_data;
  logic [DW-1:0] pix_row, pix_col;

  result_frame_reader #(.ADDR_WIDTH(AW), .DIM_WIDTH(DW), .DATA_WIDTH(DTW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .width(width), .length(length),
    .initial_addr_w(initial_addr_w), .mem_ren(mem_ren), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_data(pix_data), .pix_row(pix_row), .pix_col(pix_col),
    .pix_last(pix_last), .busy(busy), .done(done));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [DTW-1:0] data; logic [DW-1:0] row, col; logic last; } pix_t;
  typedef struct { logic [AW-1:0] addr; int due; } rd_t;

  pix_t exp_pix[$];
  logic [AW-1:0] exp_addr[$];
  rd_t mq[$];

  int n_checks = 0, n_fail = 0;
  int lat_base = 1, lat_jit = 0, ready_mode = 0, last_due = -1;
  logic [DTW-1:0] salt = '0;
  int issued_cnt, accepted_cnt, done_cnt, done_cyc, start_cyc;
  int first_ren_cyc, first_pv_cyc, last_acc_cyc;
  logic stalled = 1'b0;
  logic [DTW-1:0] held_data;
  logic [DW-1:0] held_row, held_col;
  logic held_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic flag(input string name, input logic [63:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: observed 0x%0h where nothing was expected (cycle %0d)", name, act, cyc);
  endtask

  function automatic logic [DTW-1:0] memval(input logic [AW-1:0] a);
    return a[7:0] ^ salt;
  endfunction

  // Memory: in-order responses, latency >= 1 with optional jitter
  initial begin
    rd_t r;
    int d;
    forever begin
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        r = mq.pop_front();
        mem_rvalid = 1'b1;
        mem_rdata  = memval(r.addr);
      end
      if (mem_ren) begin
        d = cyc + lat_base + int'($urandom_range(0, lat_jit));
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        mq.push_back('{mem_addr, d});
      end
    end
  end

  // Consumer back-pressure pattern
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       pix_ready = 1'b1;
      1:       pix_ready = ~pix_ready;
      default: pix_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: reads, pixel handshakes, stall stability, done pulses
  initial begin
    pix_t e;
    forever begin
      @(negedge clk);
      if (n_rst) begin stalled = 1'b0; continue; end
      if (mem_ren) begin
        check("credit_limit", 64'((issued_cnt - accepted_cnt + 1) <= FD), 1);
        issued_cnt++;
        if (first_ren_cyc < 0) first_ren_cyc = cyc;
        if (exp_addr.size() == 0) flag("unexpected_read", mem_addr);
        else check("mem_addr", mem_addr, exp_addr.pop_front());
      end
      if (stalled) begin
        if (!pix_valid) flag("valid_dropped_while_stalled", 0);
        else begin
          check("stall_data", pix_data, held_data);
          check("stall_row", pix_row, held_row);
          check("stall_col", pix_col, held_col);
          check("stall_last", pix_last, held_last);
        end
      end
      if (pix_valid) begin
        check("busy_with_pixel", busy, 1);
        if (first_pv_cyc < 0) first_pv_cyc = cyc;
        if (pix_ready) begin
          if (exp_pix.size() == 0) flag("unexpected_pixel", pix_data);
          else begin
            e = exp_pix.pop_front();
            check("pix_data", pix_data, e.data);
            check("pix_row", pix_row, e.row);
            check("pix_col", pix_col, e.col);
            check("pix_last", pix_last, e.last);
          end
          accepted_cnt++;
          last_acc_cyc = cyc;
          stalled = 1'b0;
        end else begin
          stalled   = 1'b1;
          held_data = pix_data; held_row = pix_row; held_col = pix_col; held_last = pix_last;
        end
      end else stalled = 1'b0;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_at_done", busy, 0);
      end
    end
  end

  task automatic check_reset_vals();
    check("rst_mem_ren", mem_ren, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_data", pix_data, 0);
    check("rst_pix_row", pix_row, 0);
    check("rst_pix_col", pix_col, 0);
    check("rst_pix_last", pix_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
  endtask

  // Reference model: raster order, address = base + index (mod 2^AW)
  task automatic kick(input int w, input int l, input logic [AW-1:0] base,
                      input int lat, input int jit, input int rmode, input logic [DTW-1:0] s);
    pix_t p;
    logic [AW-1:0] a;
    salt = s; lat_base = lat; lat_jit = jit; ready_mode = rmode;
    issued_cnt = 0; accepted_cnt = 0; done_cnt = 0;
    first_ren_cyc = -1; first_pv_cyc = -1; last_acc_cyc = -1; done_cyc = -1;
    for (int i = 0; i < w * l; i++) begin
      a = base + AW'(i);
      exp_addr.push_back(a);
      p.data = memval(a);
      p.row  = DW'(i / w);
      p.col  = DW'(i % w);
      p.last = (i == w * l - 1);
      exp_pix.push_back(p);
    end
    @(posedge clk); #1;
    start = 1'b1; width = DW'(w); length = DW'(l); initial_addr_w = base; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; width = DW'($urandom); length = DW'($urandom); initial_addr_w = AW'($urandom);
    check("busy_after_start", busy, 64'(w * l > 0));
  endtask

  task automatic wait_mem_idle();
    for (int k = 0; k < 200 && mq.size() > 0; k++) @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int w, input int l, input logic [AW-1:0] base,
                           input int lat, input int jit, input int rmode,
                           input logic [DTW-1:0] s, input int mid);
    int k, budget;
    budget = w * l * (lat + jit + 2) + 100;
    kick(w, l, base, lat, jit, rmode, s);
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(posedge clk); #1;
      k++;
      if (mid > 0 && k == mid) begin
        start = 1'b1; width = DW'(w + 3); length = DW'(l + 1); initial_addr_w = base + 16'h0100;
      end else start = 1'b0;
    end
    start = 1'b0;
    if (done_cnt == 0) flag("done_timeout", k);
    repeat (3) @(posedge clk);
    #1;
    check("done_pulse_count", done_cnt, 1);
    check("pixels_left", exp_pix.size(), 0);
    check("reads_left", exp_addr.size(), 0);
    check("reads_issued", issued_cnt, w * l);
    check("busy_after_frame", busy, 0);
    if (w * l == 0) check("empty_done_cycle", done_cyc, start_cyc + 2);
    else check("first_read_cycle", first_ren_cyc, start_cyc + 1);
    if (w * l > 0 && lat == 1 && jit == 0 && rmode == 0) begin
      check("first_pixel_latency", first_pv_cyc - first_ren_cyc, 2);
      check("full_throughput", last_acc_cyc - first_pv_cyc, w * l - 1);
    end
    wait_mem_idle();
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    n_rst = 1'b0;
    @(posedge clk); #1;
    check_reset_vals();

    run_frame(4, 3, 16'h0010, 1, 0, 0, 8'h00, 0);
    run_frame(4, 3, 16'h0010, 5, 0, 0, 8'h00, 0);
    run_frame(0, 5, 16'h0040, 1, 0, 0, 8'h00, 0);
    run_frame(5, 3, 16'h0100, 2, 1, 2, 8'($urandom), 4);

    // Reset in the middle of a frame while reads are still in flight
    kick(8, 4, 16'h0200, 3, 0, 0, 8'($urandom));
    repeat (10) @(posedge clk);
    #1;
    n_rst = 1'b1;
    @(posedge clk); #1;
    n_rst = 1'b0;
    exp_pix.delete();
    exp_addr.delete();
    check_reset_vals();
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("idle_after_reset", {pix_valid, busy, mem_ren}, 0);
    end
    wait_mem_idle();
    run_frame(2, 2, 16'h0300, 1, 0, 0, 8'($urandom), 0);

    for (int t = 0; t < 2; t++)
      run_frame(int'($urandom_range(1, 9)), int'($urandom_range(1, 9)), AW'($urandom),
                int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), 2, 8'($urandom), 0);

    run_frame(200, 200, 16'hFFF0, 1, 0, 1, 8'($urandom), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/result_frame_reader.md
Name: result_frame_reader

Overview:
- Reads a finished edge-detected frame back out of image memory and streams it to the host/output side as raster-ordered pixels with a valid/ready handshake.
- It is the read-back counterpart of the Sobel engine's write path. It uses the same base address and frame dimensions that were given to the engine.
- It issues credit-limited memory read requests, buffers in-order responses in a small FIFO, and tags each pixel with its row/column.

Parameters:
ADDR_WIDTH, 16, memory byte-address width; addresses wrap modulo 2^ADDR_WIDTH
DIM_WIDTH, 12, width/length/row/col counter width
DATA_WIDTH, 8, pixel width
FIFO_DEPTH, 4, response buffer entries (power of 2, >=2); also the max outstanding-plus-buffered reads

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  reset; synchronous, active-high (clears all state on a clk edge where n_rst=1)
start  in  1  single-cycle request to read one frame; ignored unless idle
width  in  DIM_WIDTH  frame width in pixels, sampled with start
length  in  DIM_WIDTH  frame height in rows, sampled with start
initial_addr_w  in  ADDR_WIDTH  base address of the frame, sampled with start
mem_ren  out  1  read request strobe, one read per asserted cycle
mem_addr  out  ADDR_WIDTH  read address, valid when mem_ren=1
mem_rvalid  in  1  read data return strobe; responses arrive in order, latency >=1, arbitrary
mem_rdata  in  DATA_WIDTH  returned byte, valid when mem_rvalid=1
pix_valid  out  1  output pixel available
pix_ready  in  1  consumer accepts the pixel when pix_valid&pix_ready
pix_data  out  DATA_WIDTH  pixel value
pix_row  out  DIM_WIDTH  row index of pix_data
pix_col  out  DIM_WIDTH  column index of pix_data
pix_last  out  1  high with the final pixel of the frame
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse once the last pixel is accepted

Behaviour:
- Reset values: mem_ren=0, mem_addr=0, pix_valid=0, pix_data=0, pix_row=0, pix_col=0, pix_last=0, busy=0, done=0. FIFO is empty, credits are full, and the FSM is in IDLE.
- FSM states are IDLE, ISSUE, DRAIN, FIN.
- IDLE: when start=1, latch width, length and base. If width==0 or length==0, go to FIN with no reads issued. Otherwise go to ISSUE.
- ISSUE: issue a read (mem_ren=1) in any cycle where outstanding+fifo_count < FIFO_DEPTH.
  - The first mem_ren occurs the cycle after start, with mem_addr = base.
  - The address increments by 1 per issued read (raster order, addr = base + r*width + c) and wraps modulo 2^ADDR_WIDTH.
  - After width*length reads are issued, go to DRAIN.
- DRAIN: no further requests. Stay until the last pixel is accepted (pix_valid & pix_ready & pix_last), then go to FIN.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE. busy=1 in ISSUE and DRAIN only.
- Credit counter:
  - outstanding increments on mem_ren and decrements on mem_rvalid. Both in the same cycle leaves it unchanged.
  - The credit check counts the read issued this cycle, so FIFO overflow is impossible.
- FIFO and output:
  - mem_rvalid pushes mem_rdata. The output register loads from the FIFO head.
  - pix_valid rises no earlier than the cycle after the corresponding mem_rvalid (1-cycle memory: first pix_valid 2 cycles after the first mem_ren).
  - Push and pop in the same cycle are both honoured.
  - pix_data, pix_row, pix_col and pix_last stay stable while pix_valid=1 and pix_ready=0.
- Output counters: pix_col increments on each accepted pixel. At width-1 it wraps to 0 and pix_row increments. pix_last = (pix_row==length-1 && pix_col==width-1).
- Throughput: with pix_ready held at 1 and 1-cycle memory latency, one pixel is delivered per cycle in steady state.
- mem_rvalid in IDLE or FIN is ignored: no push, no counter change.
- start while busy is ignored; the latched parameters do not change.
- Reset mid-frame returns to IDLE on that edge and discards FIFO contents and credits. Late responses then fall into IDLE and are ignored.
- Width rules:
  - The frame pixel count is computed in 2*DIM_WIDTH bits.
  - The address is kept in ADDR_WIDTH bits and truncates silently.

Test Plan:
- Reset then start with width=4, length=3, base=0x0010, 1-cycle memory returning data=addr[7:0], pix_ready=1 -> 12 reads at addresses 0x0010..0x001B. Pixels 0x10..0x1B arrive in order with (row,col) from (0,0) to (2,3). pix_last is high only on 0x1B. done pulses once. busy spans the frame.
- Same frame with 5-cycle memory latency and FIFO_DEPTH=4 -> never more than 4 reads outstanding-plus-buffered, and the output is identical to scenario 1.
- width=200, length=200, base=0xFFF0, pix_ready toggling 1/0 every cycle -> 40000 pixels. Addresses wrap from 0xFFFF to 0x0000. Output holds stable while stalled, and the final pix_row=199, pix_col=199.
- width=0, length=5, start -> no mem_ren, done pulses on the second cycle after start, busy stays 0.
- Assert start again mid-frame with different width -> ignored, and the frame completes with the original dimensions.
- Assert n_rst mid-frame, then return mem_rvalid responses after reset -> all outputs are at reset values and the responses are ignored. A new start (width=2, length=2) then completes cleanly with 4 pixels.
